// File: rtl/easy_fifo_pkg.sv
// Shared helpers for the FIFO-to-AXI-Stream downsizer.
//   ratio_is_legal : accepts only the supported width ratios 1, 2, 4, 8, 16
//   owidth_of      : output beat width for a given FIFO word width and ratio
//   beat_width     : width of the beat counter (kept at least 1 bit wide)
//   SKID_DEPTH     : number of whole words held between FIFO and output
package easy_fifo_pkg;

    localparam int SKID_DEPTH = 2;

    function automatic bit ratio_is_legal(input int ratio);
        return (ratio == 1) || (ratio == 2) || (ratio == 4) ||
               (ratio == 8) || (ratio == 16);
    endfunction

    function automatic int owidth_of(input int dwidth, input int ratio);
        return dwidth / ratio;
    endfunction

    function automatic int beat_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/fifo_word_skid.sv
// Two-entry word buffer (head, tail) with a registered occupancy count.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears count only)
//   push       : write push_data into the next free entry
//   push_data  : word to store
//   pop        : drop the head word; tail (if any) moves up to head
//   head       : current head word
//   count      : occupancy 0..2
// The caller must not push while full unless it pops in the same cycle.
module fifo_word_skid
    import easy_fifo_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] head,
    output logic [1:0]        count
);

    localparam logic [1:0] FULL = 2'(SKID_DEPTH);

    logic [DWIDTH-1:0] tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Data entries are deliberately not reset; count alone says what is valid.
    always_ff @(posedge clk) begin
        if (pop) begin
            if (count == FULL) begin
                head <= tail;
            end
            if (push) begin
                // The new word lands behind whatever survives the pop.
                if (count == 2'd1) begin
                    head <= push_data;
                end else begin
                    tail <= push_data;
                end
            end
        end else if (push) begin
            if (count == 2'd0) begin
                head <= push_data;
            end else begin
                tail <= push_data;
            end
        end
    end

endmodule

// File: rtl/fifo_axis_downsizer.sv
// Reads wide words from a show-ahead sync FIFO and emits each one as RATIO
// narrower AXI-Stream beats, least significant slice first.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   fifo_rd_data   : FIFO head word (only meaningful while fifo_rd_empty = 0)
//   fifo_rd_empty  : FIFO has nothing to read
//   fifo_rd_en     : pop strobe, word consumed at the same edge
//   m_axis_tdata   : output beat (DWIDTH/RATIO bits)
//   m_axis_tvalid  : beat valid
//   m_axis_tready  : downstream accepts the beat
//   m_axis_tlast   : beat is the final slice of its FIFO word
// The FIFO is read purely on buffer occupancy, never on tready, so the
// FIFO side has no combinational path from the downstream handshake.
module fifo_axis_downsizer
    import easy_fifo_pkg::*;
#(
    parameter int  DWIDTH = 32,
    parameter int  RATIO  = 4,
    localparam int OWIDTH = owidth_of(DWIDTH, RATIO)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    output logic              fifo_rd_en,
    output logic [OWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    localparam int          BW        = beat_width(RATIO);
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    if (!ratio_is_legal(RATIO)) begin : g_bad_ratio
        $error("fifo_axis_downsizer: RATIO must be 1, 2, 4, 8 or 16");
    end
    if ((DWIDTH % RATIO) != 0) begin : g_bad_width
        $error("fifo_axis_downsizer: DWIDTH must be a multiple of RATIO");
    end

    logic [DWIDTH-1:0] head;
    logic [1:0]        count;
    logic [BW-1:0]     beat;
    logic              xfer;
    logic              word_done;

    // Gated by rst so outputs are quiet from the first reset cycle, before
    // the count register has been cleared.
    assign fifo_rd_en    = ~rst & ~fifo_rd_empty & (count != 2'd2);
    assign m_axis_tvalid = ~rst & (count != 2'd0);
    assign m_axis_tlast  = m_axis_tvalid & (beat == LAST_BEAT);

    assign xfer      = m_axis_tvalid & m_axis_tready;
    assign word_done = xfer & (beat == LAST_BEAT);

    fifo_word_skid #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_rd_en),
        .push_data (fifo_rd_data),
        .pop       (word_done),
        .head      (head),
        .count     (count)
    );

    if (RATIO == 1) begin : g_no_beat
        assign beat = '0;
    end else begin : g_beat
        always_ff @(posedge clk) begin
            if (rst) begin
                beat <= '0;
            end else if (xfer) begin
                beat <= word_done ? '0 : beat + 1'b1;
            end
        end
    end

    assign m_axis_tdata = head[beat * OWIDTH +: OWIDTH];

endmodule

// File: tb/tb_fifo_axis_downsizer.sv
// Three instances (RATIO 4, 2, 1 on 32-bit words) fed from bench FIFOs.
// A word-level model tracks which words were taken and which beat is due.
module tb_fifo_axis_downsizer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rd_data [3];
    logic        empty   [3];
    logic        rd_en   [3];
    logic        tvalid  [3];
    logic        tready  [3];
    logic        tlast   [3];
    logic [31:0] tdata_w [3];
    logic        hold_empty [3];

    logic [7:0]  t4;
    logic [15:0] t2;
    logic [31:0] t1;

    fifo_axis_downsizer #(.DWIDTH(32), .RATIO(4)) u_r4 (
        .clk(clk), .rst(rst), .fifo_rd_data(rd_data[0]), .fifo_rd_empty(empty[0]),
        .fifo_rd_en(rd_en[0]), .m_axis_tdata(t4), .m_axis_tvalid(tvalid[0]),
        .m_axis_tready(tready[0]), .m_axis_tlast(tlast[0]));
    fifo_axis_downsizer #(.DWIDTH(32), .RATIO(2)) u_r2 (
        .clk(clk), .rst(rst), .fifo_rd_data(rd_data[1]), .fifo_rd_empty(empty[1]),
        .fifo_rd_en(rd_en[1]), .m_axis_tdata(t2), .m_axis_tvalid(tvalid[1]),
        .m_axis_tready(tready[1]), .m_axis_tlast(tlast[1]));
    fifo_axis_downsizer #(.DWIDTH(32), .RATIO(1)) u_r1 (
        .clk(clk), .rst(rst), .fifo_rd_data(rd_data[2]), .fifo_rd_empty(empty[2]),
        .fifo_rd_en(rd_en[2]), .m_axis_tdata(t1), .m_axis_tvalid(tvalid[2]),
        .m_axis_tready(tready[2]), .m_axis_tlast(tlast[2]));

    always_comb begin
        tdata_w[0] = {24'd0, t4};
        tdata_w[1] = {16'd0, t2};
        tdata_w[2] = t1;
    end

    // Bench-side FIFOs and word-level model state
    logic [31:0] src_mem [3][64];
    int src_wr [3];
    int src_rd [3];
    logic [31:0] taken [3][64];
    int tk [3];          // words popped from the FIFO
    int ow_idx [3];      // words fully sent or discarded
    int ob [3];          // beat index within the current word
    int xfer_cnt [3];
    int last_cnt [3];

    function automatic int ratio_of(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
    endfunction

    function automatic logic [31:0] slice_of(input logic [31:0] w, input int b, input int r);
        int ow;
        logic [63:0] m;
        ow = 32 / r;
        m  = (64'd1 << ow) - 64'd1;
        return 32'(({32'd0, w} >> (b * ow)) & m);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", name, idx, $time, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [31:0] w);
        src_mem[i][src_wr[i]] = w;
        src_wr[i]++;
    endtask

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            empty[i]   = (src_rd[i] == src_wr[i]) || hold_empty[i];
            rd_data[i] = empty[i] ? 32'hxxxx_xxxx : src_mem[i][src_rd[i]];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                ow_idx[i] <= tk[i];
                ob[i]     <= 0;
            end else begin
                if (rd_en[i]) begin
                    taken[i][tk[i]] <= rd_data[i];
                    tk[i]           <= tk[i] + 1;
                    src_rd[i]       <= src_rd[i] + 1;
                end
                if (tvalid[i] && tready[i]) begin
                    xfer_cnt[i] <= xfer_cnt[i] + 1;
                    if (tlast[i]) last_cnt[i] <= last_cnt[i] + 1;
                    if (ob[i] == ratio_of(i) - 1) begin
                        ob[i]     <= 0;
                        ow_idx[i] <= ow_idx[i] + 1;
                    end else begin
                        ob[i] <= ob[i] + 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    logic        pv [3];
    logic        pr [3];
    logic        pl [3];
    logic [31:0] pd [3];
    logic        prst = 1'b1;

    always @(negedge clk) begin
        #3;
        for (int i = 0; i < 3; i++) begin
            int cnt;
            cnt = tk[i] - ow_idx[i];
            if (rst) begin
                check("rst_tvalid", i, 32'(tvalid[i]), 32'd0);
                check("rst_tlast",  i, 32'(tlast[i]),  32'd0);
                check("rst_rd_en",  i, 32'(rd_en[i]),  32'd0);
            end else begin
                check("tvalid", i, 32'(tvalid[i]), 32'(cnt != 0));
                check("rd_en",  i, 32'(rd_en[i]),  32'(!empty[i] && cnt < 2));
                if (tvalid[i] && cnt != 0) begin
                    check("tdata_known", i, 32'($isunknown(tdata_w[i])), 32'd0);
                    check("tdata", i, tdata_w[i], slice_of(taken[i][ow_idx[i]], ob[i], ratio_of(i)));
                    check("tlast", i, 32'(tlast[i]), 32'(ob[i] == ratio_of(i) - 1));
                end
                if (pv[i] && !pr[i] && !prst) begin
                    check("stable_tvalid", i, 32'(tvalid[i]), 32'd1);
                    check("stable_tdata",  i, tdata_w[i], pd[i]);
                    check("stable_tlast",  i, 32'(tlast[i]), 32'(pl[i]));
                end
            end
            pv[i] = tvalid[i];
            pr[i] = tready[i];
            pl[i] = tlast[i];
            pd[i] = tdata_w[i];
        end
        prst = rst;
    end

    task automatic drain(input int i);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            #2;
            if (!tvalid[i] && src_rd[i] == src_wr[i]) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL drain[%0d]: stream did not empty within 200 cycles", i);
        end
        check("drain_all_sent", i, 32'(ow_idx[i]), 32'(tk[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got [4];
        logic        gl  [4];
        int base, base_x, base_l;

        for (int i = 0; i < 3; i++) begin
            tready[i] = 1'b0;
            hold_empty[i] = 1'b0;
            pv[i] = 1'b0; pr[i] = 1'b0; pl[i] = 1'b0; pd[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("reset_tvalid", 0, 32'(tvalid[0]), 32'd0);

        // Single word, RATIO 4
        tready[0] = 1'b1;
        base = tk[0];
        push(0, 32'h4433_2211);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #2;
            got[k] = tdata_w[0];
            gl[k]  = tlast[0];
        end
        check("r4_beat0", 0, got[0], 32'h11);
        check("r4_beat1", 0, got[1], 32'h22);
        check("r4_beat2", 0, got[2], 32'h33);
        check("r4_beat3", 0, got[3], 32'h44);
        check("r4_last_early", 0, 32'(gl[0] | gl[1] | gl[2]), 32'd0);
        check("r4_last_final", 0, 32'(gl[3]), 32'd1);
        @(negedge clk);
        #2;
        check("r4_idle_after", 0, 32'(tvalid[0]), 32'd0);
        check("r4_rd_pulses", 0, 32'(tk[0] - base), 32'd1);

        // RATIO 1 streaming, no bubbles
        tready[2] = 1'b1;
        for (int w = 0; w < 8; w++) push(2, 32'(w));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #2;
            check("r1_valid", 2, 32'(tvalid[2]), 32'd1);
            check("r1_data",  2, tdata_w[2], 32'(k));
            if (k < 7) check("r1_rd_en", 2, 32'(rd_en[2]), 32'd1);
        end
        @(negedge clk);
        #2;
        check("r1_idle_after", 2, 32'(tvalid[2]), 32'd0);

        // Backpressure with three words queued
        tready[0] = 1'b0;
        base = tk[0];
        push(0, 32'h4433_2211);
        push(0, 32'h8877_6655);
        push(0, 32'hCCBB_AA99);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #2;
            check("bp_data",  0, tdata_w[0], 32'h11);
            check("bp_valid", 0, 32'(tvalid[0]), 32'd1);
        end
        check("bp_rd_pulses", 0, 32'(tk[0] - base), 32'd2);
        tready[0] = 1'b1;
        drain(0);
        check("bp_words_taken", 0, 32'(tk[0] - base), 32'd3);

        // RATIO 2 with toggling ready and empty
        base   = tk[1];
        base_x = xfer_cnt[1];
        base_l = last_cnt[1];
        push(1, 32'h0BAD_F00D);
        push(1, 32'h1234_5678);
        push(1, 32'hCAFE_BABE);
        push(1, 32'h00FF_00FF);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            tready[1]     = ((c % 2) == 0);
            hold_empty[1] = ((c % 4) >= 2);
        end
        @(negedge clk);
        hold_empty[1] = 1'b0;
        tready[1]     = 1'b1;
        drain(1);
        check("r2_words", 1, 32'(tk[1] - base), 32'd4);
        check("r2_beats", 1, 32'(xfer_cnt[1] - base_x), 32'd8);
        check("r2_lasts", 1, 32'(last_cnt[1] - base_l), 32'd4);

        // Reset in the middle of a word
        tready[0] = 1'b1;
        push(0, 32'hAABB_CCDD);
        @(negedge clk);
        #2;
        check("mid_beat0", 0, tdata_w[0], 32'hDD);
        @(negedge clk);
        #2;
        check("mid_beat1", 0, tdata_w[0], 32'hCC);
        @(negedge clk);
        rst = 1'b1;
        push(0, 32'h5566_7788);
        @(negedge clk);
        #2;
        check("mid_rst_tvalid", 0, 32'(tvalid[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("post_rst_valid", 0, 32'(tvalid[0]), 32'd1);
        check("post_rst_beat0", 0, tdata_w[0], 32'h88);
        drain(0);

        // Empty FIFO with undefined data stays silent
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #2;
            check("empty_tvalid", 1, 32'(tvalid[1]), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
